// File: rtl/myfilter_pkg.sv
// Shared filter constants plus the coefficient-memory loader state and chain sizing.
package myfilter_pkg;

   localparam int unsigned CMEMSIZE        = 16;
   localparam int unsigned DATABITS        = 16;
   localparam int unsigned CMEM_CHAIN_BITS = CMEMSIZE * DATABITS;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_WAIT  = 3'd1,
      WR_SHIFT = 3'd2,
      RD_SHIFT = 3'd3,
      RD_HOLD  = 3'd4,
      DONE     = 3'd5
   } cmem_ld_state_t;

endpackage

// File: rtl/cmem_loader_shreg.sv
// W-bit shift register: parallel load has priority over a left shift that enters at the LSB.
module cmem_loader_shreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         shift_en,
   input  logic         shift_in,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         q <= '0;
      else if (load)
         q <= load_data;
      else if (shift_en)
         q <= (q << 1) | W'(shift_in);
   end

endmodule

// File: rtl/cmem_loader.sv
// Serial configuration master for the coefficient memory shift chain: word-to-bit
// writes and recirculating bit-to-word reads, MSB first, top word first.
module cmem_loader
   import myfilter_pkg::*;
#(
   parameter int unsigned MEMSIZE = CMEMSIZE,
   parameter int unsigned DBITS   = DATABITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_rd,
   input  logic [DBITS-1:0] wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [DBITS-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             busy,
   output logic             done,
   output logic             sde_out,
   output logic             sd_out,
   input  logic             sd_in
);

   localparam int unsigned WCW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
   localparam int unsigned BCW = (DBITS > 1) ? $clog2(DBITS) : 1;

   cmem_ld_state_t   state;
   logic [WCW-1:0]   word_cnt;
   logic [BCW-1:0]   bit_cnt;
   logic [DBITS-1:0] tx_q;
   logic             last_bit;
   logic             last_word;
   logic             tx_load;
   logic             tx_shift;
   logic             rx_clear;
   logic             rx_shift;

   assign last_bit  = (bit_cnt == BCW'(DBITS - 1));
   assign last_word = (word_cnt == WCW'(MEMSIZE - 1));
   assign tx_load   = (state == WR_WAIT) && wr_valid;
   assign tx_shift  = (state == WR_SHIFT);
   assign rx_clear  = (state == IDLE) && cmd_valid;
   assign rx_shift  = (state == RD_SHIFT);

   // Reads loop the chain output straight back in so contents survive the pass.
   assign sd_out = (state == RD_SHIFT) ? sd_in : tx_q[DBITS-1];

   cmem_loader_shreg #(.W(DBITS)) u_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (tx_load),
      .load_data (wr_data),
      .shift_en  (tx_shift),
      .shift_in  (1'b0),
      .q         (tx_q)
   );

   cmem_loader_shreg #(.W(DBITS)) u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (rx_clear),
      .load_data ('0),
      .shift_en  (rx_shift),
      .shift_in  (sd_in),
      .q         (rd_data)
   );

   // Control FSM; every handshake/strobe output is updated alongside the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         word_cnt  <= '0;
         bit_cnt   <= '0;
         cmd_ready <= 1'b1;
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sde_out   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               word_cnt <= '0;
               bit_cnt  <= '0;
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_rd) begin
                     state   <= RD_SHIFT;
                     sde_out <= 1'b1;
                  end else begin
                     state    <= WR_WAIT;
                     wr_ready <= 1'b1;
                  end
               end
            end
            WR_WAIT: begin
               if (wr_valid) begin
                  state    <= WR_SHIFT;
                  wr_ready <= 1'b0;
                  sde_out  <= 1'b1;
                  bit_cnt  <= '0;
               end
            end
            WR_SHIFT: begin
               if (last_bit) begin
                  bit_cnt <= '0;
                  sde_out <= 1'b0;
                  if (last_word) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     word_cnt <= word_cnt + WCW'(1);
                     state    <= WR_WAIT;
                     wr_ready <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            RD_SHIFT: begin
               if (last_bit) begin
                  bit_cnt  <= '0;
                  sde_out  <= 1'b0;
                  rd_valid <= 1'b1;
                  state    <= RD_HOLD;
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            RD_HOLD: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if (last_word) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     word_cnt <= word_cnt + WCW'(1);
                     state    <= RD_SHIFT;
                     sde_out  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmem_loader.sv
// Bench for cmem_loader with a 4 x 8-bit behavioural shift chain standing in for the memory.
module tb_cmem_loader;

   localparam int unsigned MS = 4;
   localparam int unsigned DB = 8;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_rd;
   logic [DB-1:0] wr_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [DB-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic          busy;
   logic          done;
   logic          sde_out;
   logic          sd_out;
   logic          sd_in;

   cmem_loader #(.MEMSIZE(MS), .DBITS(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_rd    (cmd_rd),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .busy      (busy),
      .done      (done),
      .sde_out   (sde_out),
      .sd_out    (sd_out),
      .sd_in     (sd_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Chain model: word k lives in chain[8k+7:8k]; shifts in at LSB, leaves from the MSB.
   logic [MS*DB-1:0] chain;
   assign sd_in = chain[MS*DB-1];
   always @(posedge clk) if (sde_out === 1'b1) chain <= {chain[MS*DB-2:0], sd_out};

   int          sde_cnt  = 0;
   int          done_cnt = 0;
   logic [31:0] bits_hist = '0;
   logic [31:0] rd_hist   = '0;
   always @(posedge clk) begin
      if (sde_out === 1'b1) begin
         bits_hist = {bits_hist[30:0], sd_out};
         sde_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) rd_hist = {rd_hist[23:0], rd_data};
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        is_rd;
      logic [31:0] words;      // write words, first sent in [31:24]
      logic [7:0]  exp_first;  // first 8 bits onto sd_out for writes
      int          gap_idx;
      int          gap_len;
      int          stall_idx;
      int          stall_len;
      logic [31:0] exp_chain;  // {addr3, addr2, addr1, addr0}
      logic [31:0] exp_rd;     // read words, first received in [31:24]
   } vec_t;

   task automatic run_vec(input vec_t v, input string tag);
      int sde_base;
      int done_base;
      int k;
      @(negedge clk);
      sde_base  = sde_cnt;
      done_base = done_cnt;
      cmd_valid = 1'b1;
      cmd_rd    = v.is_rd;
      rd_ready  = (v.stall_idx == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!v.is_rd) begin
            for (k = 0; k < 100 && wr_ready !== 1'b1; k++) @(negedge clk);
            if (wr_ready !== 1'b1) check({tag, " wr_ready timeout"}, 32'(wr_ready), 32'd1);
            if (i == v.gap_idx) begin
               for (int g = 0; g < v.gap_len; g++) begin
                  check({tag, " gap sde_out"}, 32'(sde_out), 32'd0);
                  @(negedge clk);
               end
            end
            wr_valid = 1'b1;
            wr_data  = v.words[8*(3-i) +: 8];
            @(negedge clk);
            wr_valid = 1'b0;
         end else begin
            rd_ready = (i == v.stall_idx) ? 1'b0 : 1'b1;
            for (k = 0; k < 100 && rd_valid !== 1'b1; k++) @(negedge clk);
            if (rd_valid !== 1'b1) check({tag, " rd_valid timeout"}, 32'(rd_valid), 32'd1);
            if (i == v.stall_idx) begin
               for (int s = 0; s < v.stall_len; s++) begin
                  check({tag, " stall rd_valid"}, 32'(rd_valid), 32'd1);
                  check({tag, " stall rd_data"}, 32'(rd_data), 32'(v.exp_rd[8*(3-i) +: 8]));
                  check({tag, " stall sde_out"}, 32'(sde_out), 32'd0);
                  @(negedge clk);
               end
               rd_ready = 1'b1;
            end
            @(negedge clk);
         end
      end
      for (k = 0; k < 100 && done_cnt == done_base; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      check({tag, " done pulses"}, 32'(done_cnt - done_base), 32'd1);
      check({tag, " shift cycles"}, 32'(sde_cnt - sde_base), 32'd32);
      check({tag, " chain contents"}, chain, v.exp_chain);
      check({tag, " idle after"}, {30'd0, busy, cmd_ready}, 32'd1);
      if (v.is_rd) check({tag, " read words"}, rd_hist, v.exp_rd);
      else         check({tag, " first bits"}, 32'(bits_hist[31:24]), 32'(v.exp_first));
   endtask

   vec_t vecs[7];
   int   k6;
   int   base6;

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b1;
      cmd_rd    = 1'b0;
      wr_data   = '0;
      wr_valid  = 1'b0;
      rd_ready  = 1'b1;

      vecs[0] = '{1'b0, 32'hA53C0FF0, 8'hA5, -1, 0, -1, 0, 32'hA53C0FF0, 32'h0};
      vecs[1] = '{1'b1, 32'h0,        8'h00, -1, 0, -1, 0, 32'hA53C0FF0, 32'hA53C0FF0};
      vecs[2] = '{1'b1, 32'h0,        8'h00, -1, 0,  1, 10, 32'hA53C0FF0, 32'hA53C0FF0};
      vecs[3] = '{1'b0, 32'h12345678, 8'h12, -1, 0, -1, 0, 32'h12345678, 32'h0};
      vecs[4] = '{1'b1, 32'h0,        8'h00, -1, 0, -1, 0, 32'h12345678, 32'h12345678};
      vecs[5] = '{1'b0, 32'hA53C0FF0, 8'hA5,  2, 5, -1, 0, 32'hA53C0FF0, 32'h0};
      vecs[6] = '{1'b1, 32'h0,        8'h00, -1, 0, -1, 0, 32'hA53C0FF0, 32'hA53C0FF0};

      // Reset held 3 clocks with a command pending: must stay idle.
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         check("reset outputs", {26'd0, busy, sde_out, cmd_ready, done, wr_ready, rd_valid}, 32'h8);
         check("reset rd_data", 32'(rd_data), 32'd0);
      end
      cmd_valid = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      check("post reset idle", {30'd0, busy, cmd_ready}, 32'd1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset 12 shift cycles into a write, then a fresh write/read must work normally.
      @(negedge clk);
      base6     = sde_cnt;
      cmd_valid = 1'b1;
      cmd_rd    = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_valid  = 1'b1;
      wr_data   = 8'h55;
      for (k6 = 0; k6 < 100 && (sde_cnt - base6) != 12; k6++) @(negedge clk);
      check("abort shift count", 32'(sde_cnt - base6), 32'd12);
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk);
      check("abort outputs", {29'd0, busy, sde_out, cmd_ready}, 32'd1);
      rst_n = 1'b1;
      run_vec(vecs[0], "after abort write");
      run_vec(vecs[1], "after abort read");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
